// File: rtl/stopwatch_core.sv
// Purpose : N-digit BCD stopwatch timebase with a per-digit radix (10 or 6), a tick prescaler,
//           start/stop/lap/clear/load control, preload, and count-down-to-zero.
// Latency : every output is registered. A tick's count change appears on number one cycle after the tick.
// Backpr. : none; control inputs are single-cycle pulses, and pulses that do not apply in the current state are dropped.
// Ports   : clk, rst (async, active-high); start_stop, lap, clear, load (pulses); up_down (level);
//           preload[4N-1:0] (BCD); number[4N-1:0], running, lap_active, overflow (sticky), done (pulse).
module stopwatch_core #(
  parameter int                          NUMBER_OF_DIGITS            = 4,
  parameter int                          BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int                          TICK_RATE_IN_HZ             = 100,
  parameter logic [NUMBER_OF_DIGITS-1:0] RADIX6_MASK                 = 4'b1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_stop,
  input  logic                          lap,
  input  logic                          clear,
  input  logic                          load,
  input  logic                          up_down,
  input  logic [4*NUMBER_OF_DIGITS-1:0] preload,
  output logic [4*NUMBER_OF_DIGITS-1:0] number,
  output logic                          running,
  output logic                          lap_active,
  output logic                          overflow,
  output logic                          done
);

  localparam int DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int W   = 4 * NUMBER_OF_DIGITS;

  if (DIV < 2) begin : g_bad_div
    $error("stopwatch_core: clock/tick ratio must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  state_t          state;
  logic [PW-1:0]   prescaler;
  logic [W-1:0]    count;
  logic [W-1:0]    snapshot;

  logic            tick;
  logic [W-1:0]    count_inc;
  logic [W-1:0]    count_dec;
  logic [W-1:0]    count_step;
  logic [W-1:0]    preload_sat;
  logic            inc_carry;
  logic            dec_borrow;
  logic            stop_zero;
  logic            wrap;

  function automatic logic [3:0] digit_max(input int i);
    return RADIX6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  assign tick = (state == RUNNING) && (prescaler == PW'(DIV - 1));

  // Ripple increment and ripple decrement over all digits. Each digit wraps at its own radix.
  always_comb begin
    count_inc  = count;
    count_dec  = count;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (inc_carry) begin
        if (count[4*i +: 4] >= digit_max(i)) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = digit_max(i);
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          dec_borrow = 1'b0;
        end
      end
    end
  end

  // A preload digit above its radix maximum loads as that maximum.
  always_comb begin
    preload_sat = preload;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (preload[4*i +: 4] > digit_max(i)) begin
        preload_sat[4*i +: 4] = digit_max(i);
      end
    end
  end

  // A down-count stops when it lands on zero, or when it is already at zero (this covers a start at zero).
  // The count never wraps downward.
  assign stop_zero = tick && !up_down && ((count == '0) || (count_dec == '0));
  assign wrap      = tick && up_down && inc_carry;

  always_comb begin
    count_step = count;
    if (tick) begin
      if (up_down)        count_step = count_inc;
      else if (stop_zero) count_step = '0;
      else                count_step = count_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prescaler  <= '0;
      count      <= '0;
      snapshot   <= '0;
      number     <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, PAUSED: begin
          lap_active <= 1'b0;
          if (clear) begin
            state     <= IDLE;
            count     <= '0;
            prescaler <= '0;
            overflow  <= 1'b0;
            number    <= '0;
            running   <= 1'b0;
          end else if (load) begin
            state     <= IDLE;
            count     <= preload_sat;
            prescaler <= '0;
            number    <= preload_sat;
            running   <= 1'b0;
          end else if (start_stop) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
        end

        RUNNING: begin
          // Clear and load are ignored here. A tick is always applied before any pause or lap action.
          prescaler <= tick ? '0 : prescaler + 1'b1;
          count     <= count_step;
          if (wrap) overflow <= 1'b1;

          if (stop_zero) begin
            state      <= IDLE;
            running    <= 1'b0;
            done       <= 1'b1;
            lap_active <= 1'b0;
            number     <= count_step;
          end else if (start_stop) begin
            state      <= PAUSED;
            running    <= 1'b0;
            lap_active <= 1'b0;
            number     <= count_step;
          end else if (lap) begin
            if (lap_active) begin
              lap_active <= 1'b0;
              number     <= count_step;
            end else begin
              // The snapshot captures the count as it stands this cycle, before any tick in the same cycle.
              lap_active <= 1'b1;
              snapshot   <= count;
              number     <= count;
            end
          end else begin
            number <= lap_active ? snapshot : count_step;
          end
        end

        default: begin
          state      <= IDLE;
          running    <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
